// File: rtl/mcm_pkg.sv
// Shared types and width helpers for the bit-serial multiple-constant multiplier.
// Contents:
//   state_t  controller state encoding (IDLE, RUN, DONE)
//   acc_w()  accumulator width: operand width plus coefficient width
//   cnt_w()  bit-position counter width for a given coefficient width
package mcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int acc_w(input int width, input int cw);
    return width + cw;
  endfunction

  // A 1-bit coefficient still needs a 1-bit counter.
  function automatic int cnt_w(input int cw);
    return (cw > 1) ? $clog2(cw) : 1;
  endfunction

endpackage

// File: rtl/mcm_acc_lane.sv
// One shift-add lane of the serial multiplier: holds the lane coefficient
// (consumed LSB first) and the wide accumulator.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_clr        load coefficient, clear accumulator (transaction accept)
//   i_step       perform one shift-add step
//   i_cs         coefficient to load on i_clr
//   i_xs         shifted multiplicand for the current step
//   o_acc_nxt    accumulator value including the current step's add
//   o_cs_zero    coefficient is zero after this step's shift
module mcm_acc_lane
  import mcm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 8,
  localparam int ACC_W = acc_w(WIDTH, CW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_step,
  input  logic [CW-1:0]    i_cs,
  input  logic [ACC_W-1:0] i_xs,
  output logic [ACC_W-1:0] o_acc_nxt,
  output logic             o_cs_zero
);

  logic [CW-1:0]    r_cs;
  logic [ACC_W-1:0] r_acc;

  // Exposing the post-add value lets the top capture the final product on
  // the same edge the last step commits, without an extra cycle.
  assign o_acc_nxt = r_cs[0] ? (r_acc + i_xs) : r_acc;
  assign o_cs_zero = ((r_cs >> 1) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs  <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_cs  <= i_cs;
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
      r_cs  <= r_cs >> 1;
    end
  end

endmodule

// File: rtl/mcm_serial_lanes.sv
// Bit-serial multiple-constant multiplier: y[i] = x * coef[i] for NCH lanes,
// one coefficient bit per cycle, all lanes in parallel.
// Optional build macro: MCM_EARLY_TERM_EN -- finish RUN as soon as every
// remaining coefficient bit is zero (results unchanged, latency shorter).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand set handshake
//   x                     shared multiplicand
//   coef                  lane i coefficient at coef[i*CW +: CW]
//   out_valid / out_ready result handshake
//   y                     lane i product (mod 2^WIDTH) at y[i*WIDTH +: WIDTH]
//   ovf                   lane i product did not fit in WIDTH bits
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready=1
// RUN   | one shift-add step per cycle across all lanes
// DONE  | results held on y/ovf with out_valid=1 until out_ready
module mcm_serial_lanes
  import mcm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 3,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [NCH*CW-1:0]    coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] y,
  output logic [NCH-1:0]       ovf
);

  localparam int ACC_W = acc_w(WIDTH, CW);
  localparam int CNT_W = cnt_w(CW);
`ifdef MCM_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_W-1:0]     r_xs;
  logic [CNT_W-1:0]     r_cnt;
  logic [NCH*WIDTH-1:0] r_y;
  logic [NCH-1:0]       r_ovf;

  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;
  logic                 w_all_zero;
  logic [ACC_W-1:0]     w_acc_nxt [NCH];
  logic [NCH-1:0]       w_cs_zero;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    mcm_acc_lane #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_accept),
      .i_step    (w_step),
      .i_cs      (coef[g*CW +: CW]),
      .i_xs      (r_xs),
      .o_acc_nxt (w_acc_nxt[g]),
      .o_cs_zero (w_cs_zero[g])
    );
  end

  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_step     = (r_state == RUN);
  assign w_all_zero = &w_cs_zero;
  assign w_last     = (r_cnt == CNT_W'(CW - 1)) || (EARLY_TERM && w_all_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs  <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_xs  <= {{CW{1'b0}}, x};
      r_cnt <= '0;
    end else if (w_step) begin
      r_xs  <= r_xs << 1;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Results are captured on the final RUN edge from the post-add values,
  // so they are valid the same cycle out_valid rises and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_ovf <= '0;
    end else if (w_step && w_last) begin
      for (int i = 0; i < NCH; i++) begin
        r_y[i*WIDTH +: WIDTH] <= w_acc_nxt[i][WIDTH-1:0];
        r_ovf[i]              <= |w_acc_nxt[i][ACC_W-1:WIDTH];
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign y         = r_y;
  assign ovf       = r_ovf;

endmodule
